// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the video test source and its helpers.
// Holds the one-hot FSM encoding, the RGB field layout of the pixel bus and the
// default coordinate width. pack_rgb builds a pixel word in the {r, b, g} layout.
package video_pkg;

  // Default coordinate width: enough for any realistic line or frame size.
  localparam int CW_DEFAULT = 21;

  // Pixel bus layout is {r[23:16], b[15:8], g[7:0]}; note blue sits in the middle.
  localparam int R_LSB = 16;
  localparam int B_LSB = 8;
  localparam int G_LSB = 0;

  // One-hot generator states.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_SOF    = 5'b00010,
    ST_ACTIVE = 5'b00100,
    ST_LBLANK = 5'b01000,
    ST_FBLANK = 5'b10000
  } state_t;

  // Assemble a 24-bit pixel from separate colour channels.
  function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    logic [23:0] p;
    p = '0;
    p[R_LSB +: 8] = r;
    p[G_LSB +: 8] = g;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/video_test_source_rect_hit.sv
// rect_hit: combinational inclusive test of (x, y) against a rectangle.
// Latency 0 (pure logic; the caller registers the result). No flow control.
// Ports: x, y = point under test; x0/y0 = top-left corner, x1/y1 = bottom-right
// corner (both inclusive); hit = point lies inside. x0>x1 or y0>y1 never hits.
module rect_hit
  import video_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic          hit
);

  logic in_x;
  logic in_y;

  // Unsigned compares: an inverted range fails one of the two bounds for every
  // x (or y), which is what makes an "empty" rectangle fall out for free.
  assign in_x = (x >= x0) && (x <= x1);
  assign in_y = (y >= y0) && (y <= y1);
  assign hit  = in_x && in_y;

endmodule

// File: rtl/video_test_source.sv
// video_test_source: generates WIDTH x HEIGHT frames (background plus one block
// rectangle) as a pixel/sof/eol stream with line and frame blanking.
// Latency: every output is registered, one cycle behind the FSM state that
// produced it. Backpressure: ready=0 freezes the FSM, counters and blanking
// timers; valid and sof are suppressed, pixel/eol/x/y hold, frame_done still fires.
// Ports: clk/rst (sync, active-high); run = keep producing frames; ready =
// downstream accept; block_x0/y0/x1/y1 + block_rgb + bg_rgb = pattern config,
// sampled once per frame at the SOF state; pixel_out/valid/sof/eol/x_out/y_out =
// video stream; frame_done = one pulse per completed frame; busy = not IDLE.
module video_test_source
  import video_pkg::*;
#(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int H_BLANK  = 4,
  parameter int V_BLANK  = 8,
  parameter int EOL_HOLD = 2,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          ready,
  input  logic [CW-1:0] block_x0,
  input  logic [CW-1:0] block_y0,
  input  logic [CW-1:0] block_x1,
  input  logic [CW-1:0] block_y1,
  input  logic [23:0]   block_rgb,
  input  logic [23:0]   bg_rgb,
  output logic [23:0]   pixel_out,
  output logic          valid,
  output logic          sof,
  output logic          eol,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          frame_done,
  output logic          busy
);

  // Counters are CW bits wide, so geometry and blanking lengths must fit in CW
  // bits; anything else is rejected at elaboration instead of silently wrapping.
  if ((WIDTH < 2) || (HEIGHT < 1) || (EOL_HOLD < 1) ||
      (H_BLANK < EOL_HOLD + 1) || (V_BLANK < 1) ||
      (longint'(WIDTH)   >= (longint'(1) << CW)) ||
      (longint'(HEIGHT)  >= (longint'(1) << CW)) ||
      (longint'(H_BLANK) >= (longint'(1) << CW)) ||
      (longint'(V_BLANK) >= (longint'(1) << CW))) begin : g_param_check
    $error("video_test_source: illegal geometry/blanking parameters");
  end

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] X_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] EOL_N   = CW'(EOL_HOLD);

  state_t        state;
  state_t        state_nxt;

  logic [CW-1:0] x_cnt;
  logic [CW-1:0] y_cnt;
  logic [CW-1:0] b_cnt;      // blanking timer, shared by line and frame blanking

  // Per-frame shadow copy of the pattern configuration.
  logic [CW-1:0] sh_x0;
  logic [CW-1:0] sh_y0;
  logic [CW-1:0] sh_x1;
  logic [CW-1:0] sh_y1;
  logic [23:0]   sh_blk;
  logic [23:0]   sh_bg;

  logic          done_sent;  // frame_done already issued in this FBLANK visit
  logic          hit;

  logic          x_last;
  logic          y_last;
  logic          hb_last;
  logic          vb_last;

  assign x_last  = (x_cnt == X_LAST);
  assign y_last  = (y_cnt == Y_LAST);
  assign hb_last = (b_cnt == HB_LAST);
  assign vb_last = (b_cnt == VB_LAST);

  rect_hit #(
    .CW (CW)
  ) u_rect_hit (
    .x   (x_cnt),
    .y   (y_cnt),
    .x0  (sh_x0),
    .y0  (sh_y0),
    .x1  (sh_x1),
    .y1  (sh_y1),
    .hit (hit)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ready) begin
      unique case (state)
        ST_IDLE: begin
          if (run) state_nxt = ST_SOF;
        end
        ST_SOF: begin
          state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (x_last) state_nxt = ST_LBLANK;
        end
        ST_LBLANK: begin
          if (hb_last) state_nxt = y_last ? ST_FBLANK : ST_ACTIVE;
        end
        ST_FBLANK: begin
          // run is only looked at here, so dropping it mid-frame lets the
          // current frame finish cleanly.
          if (vb_last) state_nxt = run ? ST_SOF : ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------- counters and shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      b_cnt  <= '0;
      sh_x0  <= '0;
      sh_y0  <= '0;
      sh_x1  <= '0;
      sh_y1  <= '0;
      sh_blk <= '0;
      sh_bg  <= '0;
    end else if (ready) begin
      unique case (state)
        ST_SOF: begin
          x_cnt  <= '0;
          y_cnt  <= '0;
          b_cnt  <= '0;
          sh_x0  <= block_x0;
          sh_y0  <= block_y0;
          sh_x1  <= block_x1;
          sh_y1  <= block_y1;
          sh_blk <= block_rgb;
          sh_bg  <= bg_rgb;
        end
        ST_ACTIVE: begin
          // x parks on the last column through line blanking and is cleared
          // on the way out, so x_out keeps naming the last pixel meanwhile.
          if (x_last) begin
            b_cnt <= '0;
          end else begin
            x_cnt <= x_cnt + ONE;
          end
        end
        ST_LBLANK: begin
          if (hb_last) begin
            b_cnt <= '0;
            x_cnt <= '0;
            if (!y_last) y_cnt <= y_cnt + ONE;
          end else begin
            b_cnt <= b_cnt + ONE;
          end
        end
        ST_FBLANK: begin
          b_cnt <= vb_last ? '0 : b_cnt + ONE;
        end
        default: begin
          x_cnt <= '0;
          y_cnt <= '0;
          b_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------- registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out  <= '0;
      valid      <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      done_sent  <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE);

      // frame_done ignores ready: it fires on the first cycle spent in FBLANK
      // and done_sent blocks repeats while a stall keeps the FSM parked there.
      done_sent  <= (state == ST_FBLANK);
      frame_done <= (state == ST_FBLANK) && !done_sent;

      if (state == ST_IDLE) begin
        pixel_out <= '0;
        valid     <= 1'b0;
        sof       <= 1'b0;
        eol       <= 1'b0;
        x_out     <= '0;
        y_out     <= '0;
      end else if (!ready) begin
        // Stall: nothing new is presented; pixel/eol/x/y keep their values.
        valid <= 1'b0;
        sof   <= 1'b0;
      end else begin
        valid <= (state == ST_ACTIVE);
        sof   <= (state == ST_SOF);
        eol   <= (state == ST_LBLANK) && (b_cnt < EOL_N);
        if (state == ST_SOF) begin
          // y_cnt still holds the previous frame's last line here.
          x_out <= '0;
          y_out <= '0;
        end else begin
          x_out <= x_cnt;
          y_out <= y_cnt;
        end
        if (state == ST_ACTIVE) begin
          pixel_out <= hit ? sh_blk : sh_bg;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_test_source.sv
// Self-checking bench for video_test_source with a small geometry (8x4).
// A raster-order reference (pixel index -> x,y -> rectangle rule) checks every
// valid pixel; directed scenarios cover reset, stalls, config latching, restart.
module tb_video_test_source;
  import video_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 3;
  localparam int VB = 2;
  localparam int EH = 1;
  localparam int CW = 21;

  typedef struct packed {
    logic [CW-1:0] x0;
    logic [CW-1:0] y0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic [23:0]   blk;
    logic [23:0]   bg;
  } cfg_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          ready;
  logic [CW-1:0] bx0, by0, bx1, by1;
  logic [23:0]   brgb, bgrgb;
  logic [23:0]   pixel_out;
  logic          valid, sof, eol, frame_done, busy;
  logic [CW-1:0] x_out, y_out;

  always #5 clk = ~clk;

  video_test_source #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB), .EOL_HOLD(EH), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .ready(ready),
    .block_x0(bx0), .block_y0(by0), .block_x1(bx1), .block_y1(by1),
    .block_rgb(brgb), .bg_rgb(bgrgb),
    .pixel_out(pixel_out), .valid(valid), .sof(sof), .eol(eol),
    .x_out(x_out), .y_out(y_out), .frame_done(frame_done), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference pixel: block colour inside the inclusive rectangle, else background.
  function automatic logic [23:0] ref_pixel(input cfg_t c, input int x, input int y);
    if (x >= int'(c.x0) && x <= int'(c.x1) && y >= int'(c.y0) && y <= int'(c.y1))
      return c.blk;
    return c.bg;
  endfunction

  // Monitor state
  cfg_t        cfg_q;
  cfg_t        cur;
  logic        ready_q = 1'b1;
  bit          in_frame = 0;
  bit          eol_d = 0;
  int          idx = 0, line_pix = 0, lines = 0;
  int          n_sof, n_valid, n_eol_rise, n_eol_hi, n_done, n_busy, n_c1, n_c2;
  logic [23:0] tgt1, tgt2;

  task automatic clear_counts();
    n_sof = 0; n_valid = 0; n_eol_rise = 0; n_eol_hi = 0;
    n_done = 0; n_busy = 0; n_c1 = 0; n_c2 = 0;
  endtask

  task automatic set_cfg(input int x0, input int y0, input int x1, input int y1,
                         input logic [23:0] blk, input logic [23:0] bg);
    bx0 = CW'(x0); by0 = CW'(y0); bx1 = CW'(x1); by1 = CW'(y1);
    brgb = blk; bgrgb = bg;
  endtask

  // Called at each negedge: checks the stream against the raster reference.
  task automatic sample();
    if (rst) begin
      in_frame = 0; eol_d = 0; idx = 0; line_pix = 0; lines = 0;
    end else begin
      if (!ready_q) check_eq("stall_valid", {31'b0, valid}, 0);
      if (sof) begin
        check_eq("sof_once", {31'b0, in_frame}, 0);
        in_frame = 1; cur = cfg_q; idx = 0; line_pix = 0; lines = 0;
        n_sof++;
      end
      if (valid) begin
        check_eq("valid_in_frame", {31'b0, in_frame}, 1);
        check_eq("x_pos", 32'(x_out), idx % W);
        check_eq("y_pos", 32'(y_out), idx / W);
        check_eq("pixel", {8'b0, pixel_out}, {8'b0, ref_pixel(cur, idx % W, idx / W)});
        idx++; line_pix++; n_valid++;
        if (pixel_out == tgt1) n_c1++;
        if (pixel_out == tgt2) n_c2++;
      end
      if (eol && !eol_d) begin
        check_eq("line_len", line_pix, W);
        line_pix = 0; lines++; n_eol_rise++;
      end
      if (eol) n_eol_hi++;
      eol_d = eol;
      if (frame_done) begin
        check_eq("frame_pixels", idx, W * H);
        check_eq("frame_lines", lines, H);
        in_frame = 0; n_done++;
      end
      if (busy) n_busy++;
    end
  endtask

  // One clock: monitor at negedge, capture inputs at posedge, return 1 after it.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cfg_q   = {bx0, by0, bx1, by1, brgb, bgrgb};
    ready_q = ready;
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) tick();
    check_eq("idle_timeout", {31'b0, busy}, 0);
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int frames;
    int d0;

    rst = 1'b1; run = 1'b1; ready = 1'b1;
    set_cfg(2, 1, 4, 2, 24'hFF0000, 24'h000000);
    tgt1 = 24'hFF0000; tgt2 = 24'h000001;
    clear_counts();

    // ---- reset with run high, then release
    tick(); tick();
    check_eq("rst_pixel", {8'b0, pixel_out}, 0);
    check_eq("rst_valid", {31'b0, valid}, 0);
    check_eq("rst_sof", {31'b0, sof}, 0);
    check_eq("rst_eol", {31'b0, eol}, 0);
    check_eq("rst_x", 32'(x_out), 0);
    check_eq("rst_y", 32'(y_out), 0);
    check_eq("rst_done", {31'b0, frame_done}, 0);
    check_eq("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    tick();
    check_eq("sof_early", {31'b0, sof}, 0);
    tick();
    check_eq("sof_rise", {31'b0, sof}, 1);
    check_eq("busy_rise", {31'b0, busy}, 1);
    run = 1'b0;
    wait_idle();

    // ---- single frame, rectangle (2,1)-(4,2)
    clear_counts();
    set_cfg(2, 1, 4, 2, 24'hFF0000, 24'h000000);
    tgt1 = 24'hFF0000;
    run = 1'b1; tick(); run = 1'b0;
    repeat (80) tick();
    check_eq("one_sof", n_sof, 1);
    check_eq("one_valid", n_valid, W * H);
    check_eq("one_block", n_c1, 6);
    check_eq("one_eol_rise", n_eol_rise, H);
    check_eq("one_eol_hi", n_eol_hi, H * EH);
    check_eq("one_done", n_done, 1);
    check_eq("one_busy", n_busy, 1 + H * (W + HB) + VB);

    // ---- empty rectangle (x0 > x1)
    clear_counts();
    set_cfg(5, 0, 3, 3, 24'h123456, 24'h00FF00);
    tgt1 = 24'h00FF00;
    run = 1'b1; tick(); run = 1'b0;
    repeat (80) tick();
    check_eq("empty_valid", n_valid, W * H);
    check_eq("empty_bg", n_c1, W * H);

    // ---- stall at pixel (5,0)
    clear_counts();
    set_cfg(1, 0, 6, 0, 24'hA5A5A5, 24'h0F0F0F);
    run = 1'b1; tick(); run = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (valid && x_out == 5 && y_out == 0) found = 1;
    end
    check_eq("stall_find", {31'b0, found}, 1);
    if (found) begin
      ready = 1'b0;
      repeat (3) begin
        tick();
        check_eq("stall_vld_low", {31'b0, valid}, 0);
        check_eq("stall_x_hold", 32'(x_out), 5);
      end
      ready = 1'b1;
      tick();
      check_eq("resume_vld", {31'b0, valid}, 1);
      check_eq("resume_x", 32'(x_out), 6);
    end
    wait_idle();
    check_eq("stall_valid_total", n_valid, W * H);

    // ---- config change mid-frame only takes effect at the next sof
    clear_counts();
    set_cfg(1, 0, 3, 3, 24'h0000FF, 24'h111111);
    tgt1 = 24'h0000FF; tgt2 = 24'hABCDEF;
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (valid && y_out == 1) found = 1;
    end
    check_eq("midchg_find", {31'b0, found}, 1);
    set_cfg(4, 1, 7, 2, 24'hABCDEF, 24'h222222);
    for (int i = 0; i < 200 && n_sof < 2; i++) tick();
    run = 1'b0;
    wait_idle();
    check_eq("midchg_old_blk", n_c1, 12);
    check_eq("midchg_new_blk", n_c2, 8);
    check_eq("midchg_frames", n_done, 2);

    // ---- reset mid-frame at (3,2), then restart
    clear_counts();
    set_cfg(0, 0, 2, 2, 24'h00AA00, 24'h330033);
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (valid && x_out == 3 && y_out == 2) found = 1;
    end
    check_eq("rstmid_find", {31'b0, found}, 1);
    d0 = n_done;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstmid_valid", {31'b0, valid}, 0);
    check_eq("rstmid_sof", {31'b0, sof}, 0);
    check_eq("rstmid_eol", {31'b0, eol}, 0);
    check_eq("rstmid_done", {31'b0, frame_done}, 0);
    check_eq("rstmid_busy", {31'b0, busy}, 0);
    tick();
    check_eq("restart_sof_early", {31'b0, sof}, 0);
    tick();
    check_eq("restart_sof", {31'b0, sof}, 1);
    run = 1'b0;
    tick();
    check_eq("restart_vld", {31'b0, valid}, 1);
    check_eq("restart_x", 32'(x_out), 0);
    check_eq("restart_y", 32'(y_out), 0);
    wait_idle();
    check_eq("rstmid_frames", n_done - d0, 1);

    // ---- randomized config and backpressure over several frames
    clear_counts();
    frames = 0;
    run = 1'b1;
    for (int i = 0; i < 6000 && frames < 5; i++) begin
      set_cfg($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 9),
              $urandom_range(0, 5), 24'($urandom), 24'($urandom));
      ready = ($urandom_range(0, 3) != 0);
      tick();
      if (frame_done) begin
        frames++;
        if (frames == 5) run = 1'b0;
      end
    end
    ready = 1'b1;
    wait_idle();
    check_eq("rand_frames", n_done, 5);
    check_eq("rand_valid", n_valid, 5 * W * H);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
